uart_bus_responder: RTL and testbench

//  Register-bus responder that sits between the CPU/host byte bus (wr/rd/adr/din/dout)
//  and a byte-stream serializer/deserializer pair. It answers status and data polls,

---
 rtl/uart_bus_responder.sv | 169 ++++++++++++++++
 tb/tb_uart_bus_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_responder.sv
// uart_bus_responder: byte-bus register responder bridging a host bus to a
// serializer/deserializer pair through a TX FIFO and an RX FIFO.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr, rd, adr, din    host bus write/read strobes, register address, write data
//   dout                registered host read data
//   tx_data, tx_valid   first-word-fall-through head of the TX FIFO
//   tx_ready            serializer accepts tx_data this cycle
//   rx_data, rx_valid   byte pulse from the deserializer (cannot stall)
//   rx_ready            always 1; bytes arriving while the RX FIFO is full are dropped
//
// Register map: 0 data (rd pops RX, wr pushes TX), 1 RX count, 2 status,
// 3 control (wr: bit0 flush TX, bit1 flush RX, bit2 clear sticky flags).
// Status byte: {3'b0, tx_drop, rx_ovr, tx_empty, tx_full, rx_avail}.
// Reads of address 3 return 0x00.
module uart_bus_responder #(
    parameter int unsigned AW = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic       rd,
    input  logic [1:0] adr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned PW    = AW + 1;

    localparam logic [1:0] ADR_DATA   = 2'd0;
    localparam logic [1:0] ADR_RXCNT  = 2'd1;
    localparam logic [1:0] ADR_STATUS = 2'd2;
    localparam logic [1:0] ADR_CTRL   = 2'd3;

    // Storage and state
    logic [7:0]    tx_mem_q [DEPTH];
    logic [7:0]    rx_mem_q [DEPTH];
    logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic          rx_ovr_q, rx_ovr_d;
    logic          tx_drop_q, tx_drop_d;
    logic [7:0]    dout_q, dout_d;

    // Derived FIFO conditions
    logic          tx_empty_c, tx_full_c, rx_empty_c, rx_full_c;
    logic [PW-1:0] rx_cnt_c;
    logic [7:0]    rx_cnt_byte_c;
    logic [7:0]    status_c;
    logic          tx_pop_c, tx_push_c, rx_pop_c, rx_push_c;
    logic          ctrl_wr_c, flush_tx_c, flush_rx_c, clr_flags_c;
    logic          unused_din;

    assign unused_din = ^din[7:3];

    // Full when the wrap bits differ and the index bits match
    assign tx_empty_c = (tx_wp_q == tx_rp_q);
    assign tx_full_c  = (tx_wp_q[AW] != tx_rp_q[AW]) &&
                        (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
    assign rx_empty_c = (rx_wp_q == rx_rp_q);
    assign rx_full_c  = (rx_wp_q[AW] != rx_rp_q[AW]) &&
                        (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
    assign rx_cnt_c   = rx_wp_q - rx_rp_q;

    // RX count presented as a byte, saturating only when the FIFO is deeper than 255
    if (PW > 8) begin : g_cnt_sat
        assign rx_cnt_byte_c = (rx_cnt_c > PW'(255)) ? 8'hFF : rx_cnt_c[7:0];
    end else begin : g_cnt_ext
        assign rx_cnt_byte_c = 8'(rx_cnt_c);
    end

    assign status_c = {3'b000, tx_drop_q, rx_ovr_q, tx_empty_c, tx_full_c, !rx_empty_c};

    // Stream-side outputs
    assign tx_data  = tx_mem_q[tx_rp_q[AW-1:0]];
    assign tx_valid = !tx_empty_c;
    assign rx_ready = 1'b1;
    assign dout     = dout_q;

    // Transfer decisions; a pop on a full FIFO frees the slot for a same-cycle push
    assign tx_pop_c    = tx_valid && tx_ready;
    assign tx_push_c   = wr && (adr == ADR_DATA) && (!tx_full_c || tx_pop_c);
    assign rx_pop_c    = rd && (adr == ADR_DATA) && !rx_empty_c;
    assign rx_push_c   = rx_valid && (!rx_full_c || rx_pop_c);
    assign ctrl_wr_c   = wr && (adr == ADR_CTRL);
    assign flush_tx_c  = ctrl_wr_c && din[0];
    assign flush_rx_c  = ctrl_wr_c && din[1];
    assign clr_flags_c = ctrl_wr_c && din[2];

    // Next-state: pointers, sticky flags, read data
    always_comb begin
        tx_wp_d   = tx_wp_q + PW'(tx_push_c);
        tx_rp_d   = tx_rp_q + PW'(tx_pop_c);
        rx_wp_d   = rx_wp_q + PW'(rx_push_c);
        rx_rp_d   = rx_rp_q + PW'(rx_pop_c);
        tx_drop_d = tx_drop_q;
        rx_ovr_d  = rx_ovr_q;
        dout_d    = dout_q;

        if (wr && (adr == ADR_DATA) && !tx_push_c) begin
            tx_drop_d = 1'b1;
        end
        if (rx_valid && !rx_push_c) begin
            rx_ovr_d = 1'b1;
        end
        // Flush and clear take priority over same-cycle traffic and flag sets
        if (flush_tx_c) begin
            tx_wp_d = '0;
            tx_rp_d = '0;
        end
        if (flush_rx_c) begin
            rx_wp_d = '0;
            rx_rp_d = '0;
        end
        if (clr_flags_c) begin
            tx_drop_d = 1'b0;
            rx_ovr_d  = 1'b0;
        end

        // Read data reflects state before this cycle's pushes and pops
        if (rd) begin
            unique case (adr)
                ADR_DATA:   dout_d = rx_empty_c ? 8'h00 : rx_mem_q[rx_rp_q[AW-1:0]];
                ADR_RXCNT:  dout_d = rx_cnt_byte_c;
                ADR_STATUS: dout_d = status_c;
                default:    dout_d = 8'h00;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp_q   <= '0;
            tx_rp_q   <= '0;
            rx_wp_q   <= '0;
            rx_rp_q   <= '0;
            tx_drop_q <= 1'b0;
            rx_ovr_q  <= 1'b0;
            dout_q    <= 8'h00;
        end else begin
            tx_wp_q   <= tx_wp_d;
            tx_rp_q   <= tx_rp_d;
            rx_wp_q   <= rx_wp_d;
            rx_rp_q   <= rx_rp_d;
            tx_drop_q <= tx_drop_d;
            rx_ovr_q  <= rx_ovr_d;
            dout_q    <= dout_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers gate visibility
    always_ff @(posedge clk) begin
        if (tx_push_c) begin
            tx_mem_q[tx_wp_q[AW-1:0]] <= din;
        end
        if (rx_push_c) begin
            rx_mem_q[rx_wp_q[AW-1:0]] <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Directed and randomized bench for uart_bus_responder with a queue-based reference model.
module tb_uart_bus_responder;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [1:0] adr = 2'd0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;

    uart_bus_responder #(.AW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr),
        .rd       (rd),
        .adr      (adr),
        .din      (din),
        .dout     (dout),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic       m_tx_drop = 1'b0;
    logic       m_rx_ovr  = 1'b0;
    logic [7:0] m_dout    = 8'h00;

    int checks = 0;
    int errors = 0;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_status();
        logic [7:0] s;
        s = 8'h00;
        s[0] = (rxq.size() != 0);
        s[1] = (txq.size() == DEPTH);
        s[2] = (txq.size() == 0);
        s[3] = m_rx_ovr;
        s[4] = m_tx_drop;
        return s;
    endfunction

    // Advance the model by one clock using the currently driven inputs
    task automatic model_step();
        logic pop_rx, pop_tx;
        if (rst) begin
            txq.delete();
            rxq.delete();
            m_tx_drop = 1'b0;
            m_rx_ovr  = 1'b0;
            m_dout    = 8'h00;
            return;
        end
        pop_rx = 1'b0;
        if (rd) begin
            case (adr)
                2'd0: begin
                    m_dout = (rxq.size() != 0) ? rxq[0] : 8'h00;
                    pop_rx = (rxq.size() != 0);
                end
                2'd1: m_dout = 8'(rxq.size());
                2'd2: m_dout = m_status();
                default: m_dout = 8'h00;
            endcase
        end
        pop_tx = (txq.size() != 0) && tx_ready;
        if (pop_tx) void'(txq.pop_front());
        if (wr && adr == 2'd0) begin
            if (txq.size() < DEPTH) txq.push_back(din);
            else m_tx_drop = 1'b1;
        end
        if (pop_rx) void'(rxq.pop_front());
        if (rx_valid) begin
            if (rxq.size() < DEPTH) rxq.push_back(rx_data);
            else m_rx_ovr = 1'b1;
        end
        if (wr && adr == 2'd3) begin
            if (din[0]) txq.delete();
            if (din[1]) rxq.delete();
            if (din[2]) begin
                m_tx_drop = 1'b0;
                m_rx_ovr  = 1'b0;
            end
        end
    endtask

    // One clock: update model, clock the DUT, compare outputs just after the edge
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk8("dout", dout, m_dout);
        chk8("tx_valid", 8'(tx_valid), 8'((txq.size() != 0) ? 1 : 0));
        if (txq.size() != 0) chk8("tx_data", tx_data, txq[0]);
    endtask

    task automatic idle();
        rd = 1'b0; wr = 1'b0; rx_valid = 1'b0; rst = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a);
        idle(); rd = 1'b1; adr = a; step(); rd = 1'b0;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        idle(); wr = 1'b1; adr = a; din = d; step(); wr = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] d);
        idle(); rx_valid = 1'b1; rx_data = d; step(); rx_valid = 1'b0;
    endtask

    initial begin
        // Reset, then idle status and empty data read
        rst = 1'b1; step(); step();
        idle();
        chk8("rx_ready", 8'(rx_ready), 8'h01);
        bus_rd(2'd2);
        chk8("t1_status", dout, 8'h04);
        bus_rd(2'd0);
        chk8("t1_rx_empty", dout, 8'h00);

        // TX order and pop timing
        tx_ready = 1'b0;
        bus_wr(2'd0, 8'h3A);
        bus_wr(2'd0, 8'h77);
        chk8("t2_head", tx_data, 8'h3A);
        tx_ready = 1'b1;
        idle(); step();
        chk8("t2_second", tx_data, 8'h77);
        step();
        chk8("t2_drained", 8'(tx_valid), 8'h00);
        tx_ready = 1'b0;
        bus_rd(2'd2);
        chk8("t2_status", dout, 8'h04);

        // RX receive and readback
        rx_byte(8'h0D);
        rx_byte(8'h0A);
        bus_rd(2'd2); chk8("t3_status", dout, 8'h05);
        bus_rd(2'd1); chk8("t3_count", dout, 8'h02);
        bus_rd(2'd0); chk8("t3_b0", dout, 8'h0D);
        bus_rd(2'd0); chk8("t3_b1", dout, 8'h0A);
        bus_rd(2'd0); chk8("t3_empty", dout, 8'h00);

        // TX overflow: 17th byte dropped and never emitted
        for (int i = 0; i < DEPTH; i++) bus_wr(2'd0, 8'(8'h40 + i));
        bus_wr(2'd0, 8'hEE);
        bus_rd(2'd2); chk8("t4_status", dout, 8'h12);
        bus_wr(2'd3, 8'h04);
        bus_rd(2'd2); chk8("t4_cleared", dout, 8'h02);
        tx_ready = 1'b1;
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            chk8("t4_drain", tx_data, 8'(8'h40 + i));
            step();
        end
        chk8("t4_empty", 8'(tx_valid), 8'h00);
        tx_ready = 1'b0;

        // RX full: same-cycle pop accepts, otherwise overrun
        for (int i = 0; i < DEPTH; i++) rx_byte(8'($urandom));
        idle(); rd = 1'b1; adr = 2'd0; rx_valid = 1'b1; rx_data = 8'hC3; step(); idle();
        bus_rd(2'd2); chk8("t5_no_ovr", dout, 8'h05);
        rx_byte(8'h99);
        bus_rd(2'd2); chk8("t5_ovr", dout, 8'h0D);
        bus_rd(2'd1); chk8("t5_count", dout, 8'h10);

        // Reset with both FIFOs partly full
        bus_wr(2'd3, 8'h07);
        for (int i = 0; i < DEPTH / 2; i++) begin
            idle(); wr = 1'b1; adr = 2'd0; din = 8'($urandom);
            rx_valid = 1'b1; rx_data = 8'($urandom); step();
        end
        bus_rd(2'd1);
        idle(); rst = 1'b1; rd = 1'b1; wr = 1'b1; adr = 2'd0; step(); idle();
        chk8("t6_dout", dout, 8'h00);
        chk8("t6_txv", 8'(tx_valid), 8'h00);
        bus_rd(2'd2); chk8("t6_status", dout, 8'h04);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            rst      = ($urandom_range(0, 299) == 0);
            rd       = ($urandom_range(0, 2) == 0);
            wr       = ($urandom_range(0, 2) == 0);
            adr      = 2'($urandom_range(0, 2));
            if (wr && $urandom_range(0, 24) == 0) adr = 2'd3;
            din      = 8'($urandom);
            tx_ready = ($urandom_range(0, 3) == 0);
            rx_valid = ($urandom_range(0, 1) == 0);
            rx_data  = 8'($urandom);
            step();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
